jt12_sh_ring: RTL and testbench

- Parametrised successor to the plain per-bit delay line: a width x stages slot ring for the YM2612 operator/channel pipelines.
- Data recirculates, or is shifted in from din, once per clk_en.
- A slot counter tracks which slot is entering and leaving the ring.
- A request/busy write port replaces one addressed slot in the ring without stalling it. Used for per-channel state held in time-multiplexed registers.

---
 rtl/jt12_sh_ring.sv | 123 ++++++++++++
 tb/tb_jt12_sh_ring.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_sh_ring.sv
// jt12_sh_ring: width x stages slot ring with slot counter and a
// request/busy single-slot write port for time-multiplexed state.
//
// Ports:
//   rst      sync active-high reset
//   clk      clock
//   clk_en   ring advance enable
//   din      shift-in data (used when recirc=0)
//   wr_req   write request strobe
//   wr_slot  target slot for the write
//   wr_data  data inserted into the target slot
//   wr_busy  write pending
//   wr_err   one-cycle pulse: request rejected
//   drop     last stage (ring output)
//   tap_out  stage[tap]
//   slot     index of slot at drop / entering stage 1
//   zero     slot == 0
module jt12_sh_ring #(
  parameter int              width  = 5,
  parameter int              stages = 24,
  parameter logic [width-1:0] rstval = '0,
  parameter bit              recirc = 1'b1,
  parameter int              tap    = 12,
  parameter int              cw     = 5
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             clk_en,
  input  logic [width-1:0] din,
  input  logic             wr_req,
  input  logic [cw-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_busy,
  output logic             wr_err,
  output logic [width-1:0] drop,
  output logic [width-1:0] tap_out,
  output logic [cw-1:0]    slot,
  output logic             zero
);

  localparam logic [cw:0]   NSTG = (cw+1)'(stages);
  localparam logic [cw-1:0] LAST = cw'(stages-1);

  // index 0 is stage 1, index stages-1 is stage[stages]
  logic [width-1:0] st_q [stages];
  logic [width-1:0] st_d [stages];
  logic [cw-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [cw-1:0]    ps_q, ps_d;
  logic [width-1:0] pd_q, pd_d;

  logic             hit;
  logic             slot_ok;
  logic [width-1:0] next_in;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    ps_d    = ps_q;
    pd_d    = pd_q;
    // only a registered pending write can hit, so a
    // request is never inserted in its acceptance cycle
    hit     = busy_q && (cnt_q == ps_q);
    slot_ok = {1'b0, wr_slot} < NSTG;
    if (hit) begin
      next_in = pd_q;
    end else if (recirc) begin
      next_in = st_q[stages-1];
    end else begin
      next_in = din;
    end
    if (clk_en) begin
      for (int k = 1; k < stages; k++) begin
        st_d[k] = st_q[k-1];
      end
      st_d[0] = next_in;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (hit) begin
        busy_d = 1'b0;
      end
    end
    if (wr_req) begin
      if (busy_q || !slot_ok) begin
        err_d = 1'b1;
      end else begin
        ps_d   = wr_slot;
        pd_d   = wr_data;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < stages; k++) begin
        st_q[k] <= rstval;
      end
      cnt_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      ps_q   <= '0;
      pd_q   <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      ps_q   <= ps_d;
      pd_q   <= pd_d;
    end
  end

  assign drop    = st_q[stages-1];
  assign tap_out = st_q[tap-1];
  assign slot    = cnt_q;
  assign zero    = (cnt_q == '0);
  assign wr_busy = busy_q;
  assign wr_err  = err_q;

endmodule

// File: tb/tb_jt12_sh_ring.sv
// tb_jt12_sh_ring: random + directed bench for jt12_sh_ring,
// checked against a slot-indexed memory model.
module tb_jt12_sh_ring;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       en    [2];
  logic       req   [2];
  logic [4:0] din   [2];
  logic [4:0] wslot [2];
  logic [4:0] wdata [2];
  logic       busy  [2];
  logic       err   [2];
  logic       zero  [2];
  logic [4:0] drop  [2];
  logic [4:0] tapo  [2];
  logic [4:0] a_slot;
  logic [2:0] b_slot;

  int nchk = 0;
  int nerr = 0;

  jt12_sh_ring #(
    .width(5), .stages(24), .rstval(5'h1F),
    .recirc(1'b1), .tap(12), .cw(5)
  ) dut_a (
    .rst(rst[0]), .clk(clk), .clk_en(en[0]),
    .din(din[0]), .wr_req(req[0]),
    .wr_slot(wslot[0]), .wr_data(wdata[0]),
    .wr_busy(busy[0]), .wr_err(err[0]),
    .drop(drop[0]), .tap_out(tapo[0]),
    .slot(a_slot), .zero(zero[0])
  );

  jt12_sh_ring #(
    .width(5), .stages(4), .rstval(5'h05),
    .recirc(1'b0), .tap(2), .cw(3)
  ) dut_b (
    .rst(rst[1]), .clk(clk), .clk_en(en[1]),
    .din(din[1]), .wr_req(req[1]),
    .wr_slot(wslot[1][2:0]), .wr_data(wdata[1]),
    .wr_busy(busy[1]), .wr_err(err[1]),
    .drop(drop[1]), .tap_out(tapo[1]),
    .slot(b_slot), .zero(zero[1])
  );

  // model: mem[s] is the value carried by slot s
  logic [4:0] mmem [2][24];
  int         mcnt [2];
  bit         mbusy[2];
  bit         merr [2];
  int         mps  [2];
  logic [4:0] mpd  [2];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic mstep(int id);
    int n;
    bit hit;
    bit nb;
    n = id ? 4 : 24;
    if (rst[id]) begin
      for (int i = 0; i < 24; i++)
        mmem[id][i] = id ? 5'h05 : 5'h1F;
      mcnt[id]  = 0;
      mbusy[id] = 0;
      merr[id]  = 0;
    end else begin
      hit = mbusy[id] && (mcnt[id] == mps[id]);
      nb = mbusy[id];
      merr[id] = 0;
      if (en[id]) begin
        if (hit) begin
          mmem[id][mcnt[id]] = mpd[id];
          nb = 0;
        end else if (id == 1) begin
          mmem[id][mcnt[id]] = din[id];
        end
        mcnt[id] = (mcnt[id] + 1) % n;
      end
      if (req[id]) begin
        if (mbusy[id] || int'(wslot[id]) >= n) begin
          merr[id] = 1;
        end else begin
          mps[id] = int'(wslot[id]);
          mpd[id] = wdata[id];
          nb = 1;
        end
      end
      mbusy[id] = nb;
    end
  endtask

  task automatic chk_dut(int id);
    int n;
    int tp;
    logic [31:0] sl;
    n  = id ? 4 : 24;
    tp = id ? 2 : 12;
    sl = id ? 32'(b_slot) : 32'(a_slot);
    check($sformatf("drop%0d", id), 32'(drop[id]),
          32'(mmem[id][mcnt[id]]));
    check($sformatf("tap%0d", id), 32'(tapo[id]),
          32'(mmem[id][(mcnt[id] - tp + n) % n]));
    check($sformatf("slot%0d", id), sl, mcnt[id]);
    check($sformatf("zero%0d", id), 32'(zero[id]),
          32'(mcnt[id] == 0));
    check($sformatf("busy%0d", id), 32'(busy[id]),
          32'(mbusy[id]));
    check($sformatf("err%0d", id), 32'(err[id]),
          32'(merr[id]));
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk_dut(0);
    chk_dut(1);
    req[0] = 0;
    req[1] = 0;
    rst[0] = 0;
    rst[1] = 0;
  endtask

  task automatic wait_idle(int id);
    int k;
    k = 0;
    while (busy[id] && k < 60) begin
      cyc();
      k++;
    end
    check("idle_timeout", 32'(busy[id]), 0);
  endtask

  initial begin
    int zc;
    int hits;
    int thits;
    int s;
    logic [4:0] s0;
    logic [4:0] dc;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; en[i] = 1; req[i] = 0;
      din[i] = '0; wslot[i] = '0; wdata[i] = '0;
    end
    cyc();
    check("rst_drop", 32'(drop[0]), 32'h1F);

    zc = 0;
    repeat (30) begin
      cyc();
      if (zero[0]) zc++;
    end
    check("zero_once", zc, 1);

    req[0] = 1; wslot[0] = 5'd3; wdata[0] = 5'h0A;
    cyc();
    wait_idle(0);
    hits = 0;
    thits = 0;
    repeat (48) begin
      cyc();
      if (drop[0] == 5'h0A) hits++;
      if (tapo[0] == 5'h0A) thits++;
    end
    check("drop_hits", hits, 2);
    check("tap_hits", thits, 2);

    req[0] = 1; wslot[0] = 5'd7; wdata[0] = 5'h11;
    cyc();
    cyc();
    req[0] = 1; wslot[0] = 5'd9; wdata[0] = 5'h12;
    cyc();
    check("busy_err", 32'(err[0]), 1);
    wait_idle(0);
    check("clr_slot", 32'(a_slot), 8);
    req[0] = 1; wslot[0] = 5'd24; wdata[0] = 5'h13;
    cyc();
    check("range_err", 32'(err[0]), 1);
    check("range_busy", 32'(busy[0]), 0);

    en[0] = 0;
    s0 = a_slot;
    req[0] = 1; wslot[0] = s0; wdata[0] = 5'h15;
    repeat (10) cyc();
    check("gate_busy", 32'(busy[0]), 1);
    check("gate_slot", 32'(a_slot), 32'(s0));
    en[0] = 1;
    cyc();
    check("gate_ins", 32'(busy[0]), 0);

    rst[1] = 1;
    dc = '0;
    repeat (12) begin
      din[1] = dc; dc++;
      cyc();
    end
    req[1] = 1; wslot[1] = 5'd2; wdata[1] = 5'h1E;
    repeat (12) begin
      din[1] = dc; dc++;
      cyc();
    end

    s = (int'(a_slot) + 10) % 24;
    req[0] = 1; wslot[0] = 5'(s); wdata[0] = 5'h07;
    cyc();
    check("mid_busy", 32'(busy[0]), 1);
    rst[0] = 1;
    cyc();
    check("mid_clr", 32'(busy[0]), 0);
    check("mid_slot", 32'(a_slot), 0);
    repeat (30) cyc();

    repeat (500) begin
      for (int i = 0; i < 2; i++) begin
        en[i]    = ($urandom_range(9) < 7);
        rst[i]   = ($urandom_range(63) == 0);
        req[i]   = ($urandom_range(5) == 0);
        wdata[i] = 5'($urandom);
        din[i]   = 5'($urandom);
      end
      wslot[0] = 5'($urandom_range(27));
      wslot[1] = 5'($urandom_range(7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
